div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Iterative radix-2 restoring divider for DIV/DIVU in the execute stage. Driven by the ALU when
//   alucontrolE selects a divide. Holds the pipeline via stall_o while iterating. Returns
//   {remainder, quotient}, which the pipeline carries to the MEM stage and writes into HI/LO.
// PARAMETERS
//   WIDTH  32  operand width; result is 2*WIDTH.
// PORTS
//   clk       in   1        clock; all state updates on rising edge
//   rst       in   1        synchronous, active-high reset
//   start_i   in   1        divide request; held high by E stage while the op sits in E
//   signed_i  in   1        1 = DIV (two's complement), 0 = DIVU; sampled with start
//   a_i       in   WIDTH    dividend; sampled on acceptance
//   b_i       in   WIDTH    divisor; sampled on acceptance
//   annul_i   in   1        flushE: abort current op, return to IDLE
//   stall_o   out  1        high while a divide is pending; feeds stall_divE
//   ready_o   out  1        one-cycle pulse when result_o is valid
//   result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; HI = rem, LO = quot
// BEHAVIOUR
//   - Reset: state=IDLE, counter=0, stall_o=0, ready_o=0, result_o=0. Same when rst is asserted mid-op.
//   - States:
//       IDLE -> ON    when start_i & ~annul_i
//       ON   -> ON    while cnt<WIDTH-1, cnt increments
//       ON   -> END   at cnt==WIDTH-1
//       END  -> IDLE  unconditionally
//   - On acceptance in IDLE, latch:
//       |a|, |b| (magnitudes when signed_i, raw operands otherwise)
//       neg_q = signed_i & (a[MSB]^b[MSB])
//       neg_r = signed_i & a[MSB]
//   - Each ON cycle, one restoring step:
//       rem = {rem, dividend MSB}
//       if rem >= divisor: rem -= divisor, q bit = 1; else q bit = 0
//   - END cycle: negate quotient if neg_q and remainder if neg_r; register result_o; ready_o=1.
//   - Latency: accept at cycle 0; ready_o at cycle WIDTH+1 (33 for WIDTH=32).
//   - stall_o = (IDLE & start_i) | ON. It is low in END, so the E stage advances on the ready cycle.
//   - A start_i seen in END is ignored. This is the same instruction leaving E; the next op is
//     accepted from IDLE.
//   - result_o holds its value until the next END or reset. Nothing else changes it.
//   - annul_i has priority over start_i and is honoured in any state:
//       next state IDLE, no ready_o pulse, result_o unchanged
//   - Arithmetic: the intermediate remainder is WIDTH+1 bits, so the compare does not overflow.
//     Magnitude of 0x80000000 is 0x80000000 (unsigned view).
//   - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps, no trap).
//   - Divide by zero, no macro: quotient all-ones magnitude and remainder = |a| before sign fixup
//     (architecturally UNPREDICTABLE, but deterministic).
// CONFIGURATION
//   - DIV_ZERO_FAST_EN defined:
//       b_i==0 on acceptance goes IDLE -> END directly; ready_o one cycle after acceptance
//       result_o identical to the full-iteration value
//   - Not defined: divide by zero takes the full WIDTH+1 cycle latency.
// STRUCTURE
//   - Package div_pkg: state encoding localparams (IDLE, ON, END) and counter width $clog2(WIDTH).
//   - One sub-module div_sign_fix: combinational conditional two's-complement negate, WIDTH wide.
//     Instanced for operand magnitude and for result fixup.
//   - Control FSM, counter, and shift/subtract datapath stay in div_unit.
// TESTING
//   - DIVU 100/7:
//       start -> stall_o high for cycles 0..32, ready_o at cycle 33
//       result_o = {32'd2, 32'd14}
//   - DIV -7/2:
//       result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}   (rem -1, quot -3)
//     DIV 7/-2:
//       result_o = {32'd1, 32'hFFFFFFFD}
//   - DIV 0x80000000/0xFFFFFFFF:
//       result_o = {32'd0, 32'h80000000}, no hang
//   - annul_i at cycle 10 of a divide:
//       IDLE next cycle, no ready_o, result_o keeps previous value
//       new start at cycle 12 completes normally
//   - rst mid-op at cycle 5:
//       all outputs 0 next cycle
//       start_i held through END is not re-accepted; exactly one ready_o pulse
//   - DIVU 5/0:
//       {32'd5, 32'hFFFFFFFF}
//       ready_o at cycle 1 with DIV_ZERO_FAST_EN, at cycle 33 without

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: default width, counter width, FSM states.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_END  = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               annul_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (output start_i, signed_i, a_i, b_i, annul_i,
                  input  stall_o, ready_o, result_o);
  modport slave  (input  start_i, signed_i, a_i, b_i, annul_i,
                  output stall_o, ready_o, result_o);
endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fixup.
module div_sign_fix #(parameter int WIDTH = 32) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: result {rem, quot} one cycle after the last step.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and finishes one cycle after acceptance.
module div_unit import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dvd, r_dvs, r_rem;
  logic               r_neg_q, r_neg_r, r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic             w_neg_a, w_neg_b, w_accept, w_last, w_ge, w_zero_fast;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_nxt, w_q_nxt;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic [WIDTH-1:0] w_fix_q_in, w_fix_r_in, w_q_out, w_r_out;
  logic             w_fix_nq, w_fix_nr;

  assign w_neg_a  = bus.signed_i & bus.a_i[WIDTH-1];
  assign w_neg_b  = bus.signed_i & bus.b_i[WIDTH-1];
  assign w_accept = (r_state == ST_IDLE) & bus.start_i & ~bus.annul_i;

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.i_neg(w_neg_a), .i_val(bus.a_i), .o_val(w_a_mag));
  div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.i_neg(w_neg_b), .i_val(bus.b_i), .o_val(w_b_mag));

  // Partial remainder is one bit wider so the compare cannot overflow.
  assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_q_nxt   = {r_dvd[WIDTH-2:0], w_ge};
  assign w_last    = (r_state == ST_ON) && (r_cnt == CNT_W'(WIDTH-1));

`ifdef DIV_ZERO_FAST_EN
  // Same value the full iteration would reach: every step subtracts zero.
  assign w_zero_fast = w_accept & (bus.b_i == '0);
  assign w_fix_q_in  = w_zero_fast ? '1 : w_q_nxt;
  assign w_fix_r_in  = w_zero_fast ? w_a_mag : w_rem_nxt;
  assign w_fix_nq    = w_zero_fast ? (w_neg_a ^ w_neg_b) : r_neg_q;
  assign w_fix_nr    = w_zero_fast ? w_neg_a : r_neg_r;
`else
  assign w_zero_fast = 1'b0;
  assign w_fix_q_in  = w_q_nxt;
  assign w_fix_r_in  = w_rem_nxt;
  assign w_fix_nq    = r_neg_q;
  assign w_fix_nr    = r_neg_r;
`endif

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.i_neg(w_fix_nq), .i_val(w_fix_q_in), .o_val(w_q_out));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.i_neg(w_fix_nr), .i_val(w_fix_r_in), .o_val(w_r_out));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else if (bus.annul_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (bus.start_i) begin
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_cnt   <= '0;
            if (w_zero_fast) begin
              r_state  <= ST_END;
              r_ready  <= 1'b1;
              r_result <= {w_r_out, w_q_out};
            end else begin
              r_state <= ST_ON;
            end
          end
        end
        ST_ON: begin
          r_dvd <= w_q_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state  <= ST_END;
            r_ready  <= 1'b1;
            r_result <= {w_r_out, w_q_out};
          end
        end
        ST_END: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall_o  = ((r_state == ST_IDLE) & bus.start_i) | (r_state == ST_ON);
  assign bus.ready_o  = r_ready;
  assign bus.result_o = r_result;
endmodule
